// File: rtl/alu_execute_stage.sv
// ---------------------------------------------------------------------------
// alu_execute_stage
//
// Execute-stage datapath plus the EX/MEM pipeline register. The stage takes
// the decoded ALU opcode, the forwarded operands and the shift amount from
// ID/EX. It computes the result combinationally and registers it into EX/MEM
// together with the writeback tags. The stage has one cycle of latency and
// can accept a new instruction on every cycle.
//
// Ports
//   i_clock       clock; all state changes on the rising edge
//   i_reset       synchronous, active-high reset of the EX/MEM register
//   i_stall       hold the EX/MEM contents
//   i_flush       load a bubble into EX/MEM (has priority over i_stall)
//   i_valid       an instruction is present at the stage input
//   i_alu_opcode  opcode from the ALU control decoder
//   i_operand_a   rs value after forwarding
//   i_operand_b   rt value or sign-extended immediate
//   i_shamt       instruction shamt field
//   i_reg_write   writeback enable tag
//   i_write_reg   destination register
//   o_alu_result  registered result
//   o_zero        registered (result == 0)
//   o_illegal     registered unknown-opcode flag
//   o_valid       EX/MEM slot holds an instruction
//   o_reg_write   registered writeback enable (never set for illegal ops)
//   o_write_reg   registered destination register
// ---------------------------------------------------------------------------
module alu_execute_stage #(
  parameter int NB_DATA     = 32,
  parameter int NB_OP_FIELD = 6,
  parameter int NB_SHAMT    = 5,
  parameter int NB_REG_ADDR = 5
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_valid,
  input  logic [NB_OP_FIELD-1:0] i_alu_opcode,
  input  logic [NB_DATA-1:0]     i_operand_a,
  input  logic [NB_DATA-1:0]     i_operand_b,
  input  logic [NB_SHAMT-1:0]    i_shamt,
  input  logic                   i_reg_write,
  input  logic [NB_REG_ADDR-1:0] i_write_reg,
  output logic [NB_DATA-1:0]     o_alu_result,
  output logic                   o_zero,
  output logic                   o_illegal,
  output logic                   o_valid,
  output logic                   o_reg_write,
  output logic [NB_REG_ADDR-1:0] o_write_reg
);

  // Opcode encodings produced by the ALU control decoder.
  localparam logic [NB_OP_FIELD-1:0] OP_SLL  = NB_OP_FIELD'(6'b000000);
  localparam logic [NB_OP_FIELD-1:0] OP_SRL  = NB_OP_FIELD'(6'b000010);
  localparam logic [NB_OP_FIELD-1:0] OP_SRA  = NB_OP_FIELD'(6'b000011);
  localparam logic [NB_OP_FIELD-1:0] OP_SLLV = NB_OP_FIELD'(6'b000100);
  localparam logic [NB_OP_FIELD-1:0] OP_SRLV = NB_OP_FIELD'(6'b000110);
  localparam logic [NB_OP_FIELD-1:0] OP_SRAV = NB_OP_FIELD'(6'b000111);
  localparam logic [NB_OP_FIELD-1:0] OP_ADDU = NB_OP_FIELD'(6'b100001);
  localparam logic [NB_OP_FIELD-1:0] OP_SUBU = NB_OP_FIELD'(6'b100011);
  localparam logic [NB_OP_FIELD-1:0] OP_AND  = NB_OP_FIELD'(6'b100100);
  localparam logic [NB_OP_FIELD-1:0] OP_OR   = NB_OP_FIELD'(6'b100101);
  localparam logic [NB_OP_FIELD-1:0] OP_XOR  = NB_OP_FIELD'(6'b100110);
  localparam logic [NB_OP_FIELD-1:0] OP_NOR  = NB_OP_FIELD'(6'b100111);
  localparam logic [NB_OP_FIELD-1:0] OP_SLT  = NB_OP_FIELD'(6'b101010);
  localparam logic [NB_OP_FIELD-1:0] OP_LUI  = NB_OP_FIELD'(6'b101011);
  localparam logic [NB_OP_FIELD-1:0] OP_ADD  = NB_OP_FIELD'(6'b110001);

  // The variable shifts use only the low shamt-width bits of operand a.
  logic [NB_SHAMT-1:0] var_shamt;
  logic [NB_DATA-1:0]  alu_out;
  logic                unknown_op;

  assign var_shamt = i_operand_a[NB_SHAMT-1:0];

  always_comb begin
    // NOTE: every signal driven here gets a default first, so that no opcode
    // path leaves it unassigned and a latch is inferred.
    alu_out    = '0;
    unknown_op = 1'b0;
    unique case (i_alu_opcode)
      OP_SLL:  alu_out = i_operand_b << i_shamt;
      OP_SRL:  alu_out = i_operand_b >> i_shamt;
      OP_SRA:  alu_out = $unsigned($signed(i_operand_b) >>> i_shamt);
      OP_SLLV: alu_out = i_operand_b << var_shamt;
      OP_SRLV: alu_out = i_operand_b >> var_shamt;
      OP_SRAV: alu_out = $unsigned($signed(i_operand_b) >>> var_shamt);
      OP_ADDU,
      OP_ADD:  alu_out = i_operand_a + i_operand_b;  // wraps; no overflow trap
      OP_SUBU: alu_out = i_operand_a - i_operand_b;
      OP_AND:  alu_out = i_operand_a & i_operand_b;
      OP_OR:   alu_out = i_operand_a | i_operand_b;
      OP_XOR:  alu_out = i_operand_a ^ i_operand_b;
      OP_NOR:  alu_out = ~(i_operand_a | i_operand_b);
      OP_SLT:  alu_out = {{(NB_DATA-1){1'b0}},
                          ($signed(i_operand_a) < $signed(i_operand_b))};
      OP_LUI:  alu_out = i_operand_b << 16;
      default: unknown_op = 1'b1;
    endcase
  end

  // EX/MEM register. Reset beats flush, and flush beats stall. A flush or a
  // reset during a stall drops the held instruction; it is not replayed.
  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values that existed before the clock edge.
    if (i_reset) begin
      o_alu_result <= '0;
      o_zero       <= 1'b0;
      o_illegal    <= 1'b0;
      o_valid      <= 1'b0;
      o_reg_write  <= 1'b0;
      o_write_reg  <= '0;
    end else if (i_flush) begin
      // Bubble: only the qualifiers clear; the data fields keep their values.
      o_valid     <= 1'b0;
      o_reg_write <= 1'b0;
      o_illegal   <= 1'b0;
    end else if (!i_stall) begin
      o_valid      <= i_valid;
      o_alu_result <= i_valid ? alu_out : '0;
      o_zero       <= i_valid && (alu_out == '0);
      o_illegal    <= i_valid && unknown_op;
      o_reg_write  <= i_valid && i_reg_write && !unknown_op;
      o_write_reg  <= i_write_reg;
    end
  end

endmodule
